keypad_scanner: RTL

- Input-side counterpart of the row-scanned LED matrix driver. It drives a 4x4 button matrix one row at a time and samples the columns.
- Each of the 16 keys is debounced. The block outputs a stable key map, one-cycle press pulses, and a single-entry key-event register with an acknowledge.
- It replaces the raw KEY[3:0] inputs feeding the bank/score logic. The game can then use 16 pads, or 4 pads with the remaining keys as menu/speed keys.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/key_debounce.sv | 62 ++++++
 rtl/keypad_scanner.sv | 132 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Optional release events are enabled with the RELEASE_EVT_EN macro (see keypad_scanner).
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [3:0]          key_idx_t;
    typedef logic [1:0]          row_idx_t;
    typedef logic [NUM_KEYS-1:0] key_vec_t;

    function automatic key_idx_t key_index(input int unsigned row, input int unsigned col);
        return key_idx_t'(row * NUM_COLS + col);
    endfunction

    // Lowest set bit wins; returns 0 for an empty vector.
    function automatic key_idx_t lowest_key(input key_vec_t v);
        key_idx_t idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = key_idx_t'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_hot(input key_vec_t v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: the state flips after DEBOUNCE consecutive disagreeing samples.
// The state updates only on the key's sample strobe; rise/fall are one-cycle pulses.
module key_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    input  logic raw,
    output logic state,
    output logic rise,
    output logic fall
);

    localparam int            CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample) begin
            if (raw == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = ~state_q;
                rise_d  = ~state_q;
                fall_d  = state_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state = state_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanned 4x4 keypad with per-key debounce and a single-entry event register.
// Define RELEASE_EVT_EN to also report debounced releases as events.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1024,
    parameter int SETTLE   = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic [NUM_ROWS-1:0] Row_Drv,
    input  logic [NUM_COLS-1:0] Col_In,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                evt_valid,
    output logic [3:0]          evt_code,
    output logic                evt_release,
    input  logic                evt_ack,
    output logic                evt_overflow
);

    localparam int            DW           = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_SAMPLE = DW'(SETTLE - 1);

    row_idx_t              row_q, row_d;
    logic [DW-1:0]         dwell_q, dwell_d;
    logic [NUM_ROWS-1:0]   row_drv_q, row_drv_d;
    logic                  sample_strobe;
    key_vec_t              key_fall;

    always_comb begin
        dwell_d = dwell_q + 1'b1;
        row_d   = row_q;
        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            row_d   = row_q + 1'b1;
        end
        row_drv_d = ~(4'b0001 << row_d);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            row_q     <= '0;
            dwell_q   <= '0;
            row_drv_q <= 4'b1110;
        end else begin
            row_q     <= row_d;
            dwell_q   <= dwell_d;
            row_drv_q <= row_drv_d;
        end
    end

    assign Row_Drv       = row_drv_q;
    assign sample_strobe = (dwell_q == DWELL_SAMPLE);

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            localparam key_idx_t K = key_index(r, c);
            key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
                .clk    (Clock),
                .rst_n  (Reset),
                .sample (sample_strobe && (row_q == row_idx_t'(r))),
                .raw    (~Col_In[c]),
                .state  (key_state[K]),
                .rise   (key_press[K]),
                .fall   (key_fall[K])
            );
        end
    end

    key_vec_t cand_all;
    key_idx_t pick_code;
    logic     pick_rel;

`ifdef RELEASE_EVT_EN
    // Presses take priority over releases raised in the same cycle.
    assign cand_all  = key_press | key_fall;
    assign pick_rel  = ~|key_press;
    assign pick_code = pick_rel ? lowest_key(key_fall) : lowest_key(key_press);
`else
    logic unused_fall;
    assign unused_fall = ^key_fall;
    assign cand_all    = key_press;
    assign pick_rel    = 1'b0;
    assign pick_code   = lowest_key(key_press);
`endif

    logic     evt_valid_q, evt_valid_d;
    key_idx_t evt_code_q, evt_code_d;
    logic     evt_release_q, evt_release_d;
    logic     evt_overflow_q, evt_overflow_d;
    logic     cand_any, evt_load;

    always_comb begin
        evt_valid_d    = evt_valid_q;
        evt_code_d     = evt_code_q;
        evt_release_d  = evt_release_q;
        evt_overflow_d = evt_overflow_q;
        cand_any       = |cand_all;
        evt_load       = cand_any && (!evt_valid_q || evt_ack);
        if (evt_valid_q && evt_ack) evt_valid_d = 1'b0;
        // A load after the pop above lets ack-and-reload happen without a bubble.
        if (evt_load) begin
            evt_valid_d   = 1'b1;
            evt_code_d    = pick_code;
            evt_release_d = pick_rel;
        end
        if (cand_any && (!evt_load || multi_hot(cand_all))) evt_overflow_d = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            evt_valid_q    <= 1'b0;
            evt_code_q     <= '0;
            evt_release_q  <= 1'b0;
            evt_overflow_q <= 1'b0;
        end else begin
            evt_valid_q    <= evt_valid_d;
            evt_code_q     <= evt_code_d;
            evt_release_q  <= evt_release_d;
            evt_overflow_q <= evt_overflow_d;
        end
    end

    assign evt_valid    = evt_valid_q;
    assign evt_code     = evt_code_q;
    assign evt_release  = evt_release_q;
    assign evt_overflow = evt_overflow_q;

endmodule
